// File: rtl/sprite_plane_if.sv
// Raster position, control-register and bitmap-write bus feeding one sprite plane.
// No valid/ready: every signal is sampled on every clkv edge and the raster advances each cycle.
interface sprite_plane_if #(
   parameter int SPRITE_BITS = 4,
   parameter int COLOR_WIDTH = 32
);
   logic signed [31:0]            count_h;
   logic signed [31:0]            count_v;
   logic                          reg_we;
   logic [1:0]                    reg_addr;
   logic [31:0]                   reg_data;
   logic                          bmp_we;
   logic [2*SPRITE_BITS-1:0]      bmp_addr;
   logic [COLOR_WIDTH-1:0]        bmp_data;

   modport master (
      output count_h, count_v, reg_we, reg_addr, reg_data, bmp_we, bmp_addr, bmp_data
   );
   modport slave (
      input count_h, count_v, reg_we, reg_addr, reg_data, bmp_we, bmp_addr, bmp_data
   );
endinterface

// File: rtl/sprite_plane.sv
// Single sprite layer: double-buffered placement registers, rectangle hit test and
// bitmap lookup, producing a colour word three clkv cycles after the raster sample.
module sprite_plane #(
   parameter int SPRITE_BITS = 4,
   parameter int COLOR_WIDTH = 32
) (
   input  logic                   clkv,
   input  logic                   resetv,
   sprite_plane_if.slave          bus,
   output logic [COLOR_WIDTH-1:0] color
);
   localparam int AW = 2 * SPRITE_BITS;

   logic signed [31:0] sh_pos_x, sh_pos_y, act_pos_x, act_pos_y;
   logic signed [31:0] nx_pos_x, nx_pos_y, eff_pos_x, eff_pos_y;
   logic [1:0]         sh_scale, act_scale, nx_scale, eff_scale;
   logic               sh_en, act_en, nx_en, eff_en;
   logic               frame_start;

   assign frame_start = (bus.count_h == 32'sd0) && (bus.count_v == 32'sd0);

   // Shadow values including this cycle's write, so a write in the commit cycle is committed.
   always_comb begin
      nx_pos_x = sh_pos_x;
      nx_pos_y = sh_pos_y;
      nx_scale = sh_scale;
      nx_en    = sh_en;
      if (bus.reg_we) begin
         case (bus.reg_addr)
            2'd0:    nx_pos_x = bus.reg_data;
            2'd1:    nx_pos_y = bus.reg_data;
            2'd2:    nx_scale = (bus.reg_data[1:0] == 2'd3) ? 2'd2 : bus.reg_data[1:0];
            default: nx_en    = bus.reg_data[0];
         endcase
      end
   end

   // The first pixel of a frame already sees the values being committed.
   assign eff_pos_x = frame_start ? nx_pos_x : act_pos_x;
   assign eff_pos_y = frame_start ? nx_pos_y : act_pos_y;
   assign eff_scale = frame_start ? nx_scale : act_scale;
   assign eff_en    = frame_start ? nx_en    : act_en;

   always_ff @(posedge clkv) begin
      if (resetv) begin
         sh_pos_x  <= 32'sd0;
         sh_pos_y  <= 32'sd0;
         sh_scale  <= 2'd0;
         sh_en     <= 1'b0;
         act_pos_x <= 32'sd0;
         act_pos_y <= 32'sd0;
         act_scale <= 2'd0;
         act_en    <= 1'b0;
      end else begin
         sh_pos_x <= nx_pos_x;
         sh_pos_y <= nx_pos_y;
         sh_scale <= nx_scale;
         sh_en    <= nx_en;
         if (frame_start) begin
            act_pos_x <= nx_pos_x;
            act_pos_y <= nx_pos_y;
            act_scale <= nx_scale;
            act_en    <= nx_en;
         end
      end
   end

   logic signed [31:0]     dx, dy, edge_len;
   logic [SPRITE_BITS-1:0] col, row;
   logic                   hit0;

   always_comb begin
      dx       = bus.count_h - eff_pos_x;
      dy       = bus.count_v - eff_pos_y;
      edge_len = 32'sd1 <<< (SPRITE_BITS + 32'(eff_scale));
      col      = SPRITE_BITS'($unsigned(dx) >> eff_scale);
      row      = SPRITE_BITS'($unsigned(dy) >> eff_scale);
      hit0     = eff_en && (dx >= 32'sd0) && (dx < edge_len)
                        && (dy >= 32'sd0) && (dy < edge_len);
   end

   logic          hit1, hit2;
   logic [AW-1:0] addr1;

   always_ff @(posedge clkv) begin
      if (resetv) begin
         hit1  <= 1'b0;
         addr1 <= '0;
      end else begin
         hit1  <= hit0;
         addr1 <= {row, col};
      end
   end

   // Bitmap survives reset; a read of the address being written returns the old word.
   logic [COLOR_WIDTH-1:0] mem [2**AW];
   logic [COLOR_WIDTH-1:0] ram_q;

   always_ff @(posedge clkv) begin
      if (bus.bmp_we) mem[bus.bmp_addr] <= bus.bmp_data;
   end

   always_ff @(posedge clkv) begin
      if (resetv) begin
         ram_q <= '0;
         hit2  <= 1'b0;
      end else begin
         ram_q <= mem[addr1];
         hit2  <= hit1;
      end
   end

   always_ff @(posedge clkv) begin
      if (resetv) color <= '0;
      else        color <= hit2 ? ram_q : '0;
   end
endmodule
